// File: rtl/hist_ram_scheduler_if.sv
// Bus bundle for the histogram RAM scheduler: pixel stream, sweep stream,
// control/status and the simple dual-port BRAM port.
interface hist_ram_scheduler_if #(
  parameter int unsigned CW = 21
);
  logic          clear_req;
  logic          accum_en;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready;
  logic          sweep_req;
  logic          sweep_valid;
  logic [7:0]    sweep_bin;
  logic [CW-1:0] sweep_count;
  logic          sweep_last;
  logic          clear_done;
  logic          busy;
  logic          overflow;
  logic [7:0]    ram_rd_addr;
  logic [CW-1:0] ram_rd_data;
  logic          ram_we;
  logic [7:0]    ram_wr_addr;
  logic [CW-1:0] ram_wr_data;

  modport slave (
    input  clear_req, accum_en, pix_valid, pix_data, sweep_req, ram_rd_data,
    output pix_ready, sweep_valid, sweep_bin, sweep_count, sweep_last,
           clear_done, busy, overflow, ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data
  );

  modport master (
    output clear_req, accum_en, pix_valid, pix_data, sweep_req, ram_rd_data,
    input  pix_ready, sweep_valid, sweep_bin, sweep_count, sweep_last,
           clear_done, busy, overflow, ram_rd_addr, ram_we, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/hist_ram_scheduler.sv
// Shares the 256-bin histogram BRAM between clear, pixel accumulation (RMW with
// one-deep forwarding) and the sequential CDF sweep reader.
module hist_ram_scheduler #(
  parameter int unsigned CW = 21
) (
  input logic                 clk,
  input logic                 reset,
  hist_ram_scheduler_if.slave bus
);

  localparam int unsigned BW = 8;
  localparam logic [BW-1:0] LAST_BIN = {BW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_SWEEP = 2'd3;

  logic [1:0]    state_q,       state_d;
  logic [BW-1:0] clr_cnt_q,     clr_cnt_d;
  logic [BW-1:0] rd_cnt_q,      rd_cnt_d;
  logic          rd_done_q,     rd_done_d;
  logic          s1_valid_q,    s1_valid_d;
  logic [BW-1:0] s1_addr_q,     s1_addr_d;
  logic          fwd_valid_q,   fwd_valid_d;
  logic [BW-1:0] fwd_addr_q,    fwd_addr_d;
  logic [CW-1:0] fwd_data_q,    fwd_data_d;
  logic          overflow_q,    overflow_d;
  logic          clear_done_q,  clear_done_d;
  logic          sweep_valid_q, sweep_valid_d;
  logic [BW-1:0] sweep_bin_q,   sweep_bin_d;
  logic          sweep_last_q,  sweep_last_d;

  logic          pix_ready_c;
  logic          accept_c;
  logic [CW-1:0] base_c;
  logic          sat_c;
  logic [CW-1:0] inc_c;
  logic [BW-1:0] rd_addr_c;
  logic          we_c;
  logic [BW-1:0] wr_addr_c;
  logic [CW-1:0] wr_data_c;

  // Forwarding covers the read-first BRAM returning stale data for back-to-back hits.
  always_comb begin
    base_c = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : bus.ram_rd_data;
    sat_c  = (base_c == CNT_MAX);
    inc_c  = sat_c ? base_c : CW'(base_c + CW'(1));
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    rd_done_d     = rd_done_q;
    s1_valid_d    = 1'b0;
    s1_addr_d     = s1_addr_q;
    fwd_valid_d   = fwd_valid_q;
    fwd_addr_d    = fwd_addr_q;
    fwd_data_d    = fwd_data_q;
    overflow_d    = overflow_q;
    clear_done_d  = 1'b0;
    sweep_valid_d = 1'b0;
    sweep_bin_d   = sweep_bin_q;
    sweep_last_d  = 1'b0;
    rd_addr_c     = '0;
    we_c          = 1'b0;
    wr_addr_c     = '0;
    wr_data_c     = '0;
    pix_ready_c   = (state_q == S_ACCUM) && bus.accum_en;
    accept_c      = pix_ready_c && bus.pix_valid;

    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d    = S_CLEAR;
          clr_cnt_d  = '0;
          overflow_d = 1'b0;
        end else if (bus.sweep_req) begin
          state_d   = S_SWEEP;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end else if (bus.accum_en) begin
          state_d = S_ACCUM;
        end
      end
      S_CLEAR: begin
        we_c      = 1'b1;
        wr_addr_c = clr_cnt_q;
        if (clr_cnt_q == LAST_BIN) begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = BW'(clr_cnt_q + BW'(1));
        end
      end
      S_ACCUM: begin
        if (accept_c) begin
          rd_addr_c  = bus.pix_data;
          s1_valid_d = 1'b1;
          s1_addr_d  = bus.pix_data;
        end
        if (!bus.accum_en) begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        // Hold SWEEP until the bin-255 word has been presented.
        if (sweep_last_q) begin
          state_d = S_IDLE;
        end else if (!rd_done_q) begin
          rd_addr_c     = rd_cnt_q;
          sweep_valid_d = 1'b1;
          sweep_bin_d   = rd_cnt_q;
          sweep_last_d  = (rd_cnt_q == LAST_BIN);
          if (rd_cnt_q == LAST_BIN) begin
            rd_done_d = 1'b1;
          end else begin
            rd_cnt_d = BW'(rd_cnt_q + BW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (s1_valid_q) begin
      we_c        = 1'b1;
      wr_addr_c   = s1_addr_q;
      wr_data_c   = inc_c;
      fwd_valid_d = 1'b1;
      fwd_addr_d  = s1_addr_q;
      fwd_data_d  = inc_c;
      if (sat_c) begin
        overflow_d = 1'b1;
      end
    end

    if (state_d != S_ACCUM) begin
      fwd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      rd_cnt_q      <= '0;
      rd_done_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_addr_q    <= '0;
      fwd_data_q    <= '0;
      overflow_q    <= 1'b0;
      clear_done_q  <= 1'b0;
      sweep_valid_q <= 1'b0;
      sweep_bin_q   <= '0;
      sweep_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_done_q     <= rd_done_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_addr_q    <= fwd_addr_d;
      fwd_data_q    <= fwd_data_d;
      overflow_q    <= overflow_d;
      clear_done_q  <= clear_done_d;
      sweep_valid_q <= sweep_valid_d;
      sweep_bin_q   <= sweep_bin_d;
      sweep_last_q  <= sweep_last_d;
    end
  end

  assign bus.pix_ready   = pix_ready_c;
  assign bus.ram_rd_addr = rd_addr_c;
  assign bus.ram_we      = we_c;
  assign bus.ram_wr_addr = wr_addr_c;
  assign bus.ram_wr_data = wr_data_c;
  assign bus.sweep_valid = sweep_valid_q;
  assign bus.sweep_bin   = sweep_bin_q;
  assign bus.sweep_count = sweep_valid_q ? bus.ram_rd_data : '0;
  assign bus.sweep_last  = sweep_last_q;
  assign bus.clear_done  = clear_done_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q != S_IDLE) || s1_valid_q || sweep_valid_q;

endmodule

// File: tb/tb_hist_ram_scheduler.sv
// Directed bench for hist_ram_scheduler with a read-first BRAM model, a
// reference histogram and a sweep-word scoreboard.
module tb_hist_ram_scheduler;

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct packed {
    logic [7:0]    bin;
    logic [CW-1:0] cnt;
    logic          last;
  } word_t;

  logic clk;
  logic reset;
  hist_ram_scheduler_if #(.CW(CW)) bus ();

  hist_ram_scheduler #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM: the registered read sees the value before a same-cycle write.
  logic [CW-1:0] mem [256];
  logic [CW-1:0] rd_data_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    rd_data_q <= mem[bus.ram_rd_addr];
  end
  assign bus.ram_rd_data = rd_data_q;

  int    vectors = 0;
  int    miscompares = 0;
  int    words_seen = 0;
  int    sum_seen = 0;
  int    hist [256];
  logic  ovf_exp = 1'b0;
  word_t exp_q [$];
  word_t w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweep monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.sweep_valid === 1'b1) begin
      chk("sweep_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sweep_word", 32'({bus.sweep_bin, bus.sweep_count, bus.sweep_last}),
            32'({w.bin, w.cnt, w.last}));
        words_seen++;
        sum_seen += int'(bus.sweep_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2000 && bus.busy !== 1'b0; i++) @(negedge clk);
    chk(tag, 32'(bus.busy), 32'(0));
    step();
  endtask

  task automatic do_clear(input bit with_sweep);
    bus.clear_req = 1'b1;
    bus.sweep_req = with_sweep;
    step();
    bus.clear_req = 1'b0;
    bus.sweep_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("clear_write", 32'({bus.ram_we, bus.ram_wr_addr, bus.ram_wr_data, bus.clear_done}),
          32'({1'b1, 8'(i), {CW{1'b0}}, 1'b0}));
      if (i == 0) chk("clear_ovf", 32'(bus.overflow), 32'(0));
      bus.sweep_req = with_sweep && (i == 10);
    end
    @(negedge clk);
    chk("clear_done", 32'({bus.clear_done, bus.busy, bus.ram_we}), 32'(3'b100));
    @(negedge clk);
    chk("clear_done_pulse", 32'(bus.clear_done), 32'(0));
    for (int b = 0; b < 256; b++) hist[b] = 0;
    ovf_exp = 1'b0;
    step();
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit gaps);
    bit done = 1'b0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.pix_valid = 1'b0;
      step();
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.pix_ready === 1'b1) begin
        done = 1'b1;
        if (hist[d] == int'(CMAX)) ovf_exp = 1'b1;
        else hist[d]++;
      end
      step();
    end
    chk("pix_accepted", 32'(done), 32'(1));
  endtask

  task automatic end_accum();
    bus.pix_valid = 1'b0;
    bus.accum_en  = 1'b0;
    @(negedge clk);
    chk("pix_ready_drop", 32'(bus.pix_ready), 32'(0));
    wait_idle("accum_idle");
    chk("overflow", 32'(bus.overflow), 32'(ovf_exp));
  endtask

  task automatic do_sweep();
    int model_sum = 0;
    words_seen = 0;
    sum_seen   = 0;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back('{bin: 8'(b), cnt: CW'(hist[b]), last: (b == 255)});
      model_sum += hist[b];
    end
    bus.sweep_req = 1'b1;
    step();
    bus.sweep_req = 1'b0;
    wait_idle("sweep_idle");
    chk("sweep_words", 32'(words_seen), 32'(256));
    chk("sweep_sum", 32'(sum_seen), 32'(model_sum));
    chk("sweep_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [5];
    pat[0] = 8'd5; pat[1] = 8'd5; pat[2] = 8'd5; pat[3] = 8'd7; pat[4] = 8'd5;
    for (int b = 0; b < 256; b++) begin
      mem[b]  = CW'(b + 3);
      hist[b] = 0;
    end
    reset = 1'b1;
    bus.clear_req = 1'b0;
    bus.accum_en  = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    bus.sweep_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", 32'({bus.pix_ready, bus.sweep_valid, bus.sweep_last, bus.clear_done,
                              bus.busy, bus.overflow, bus.ram_we}), 32'(0));
    step();
    reset = 1'b0;
    step();

    // Clear, then 5,5,5,7,5 back to back.
    do_clear(1'b0);
    bus.accum_en = 1'b1;
    for (int i = 0; i < 5; i++) send_pixel(pat[i], 1'b0);
    end_accum();
    chk("model_bin5", 32'(hist[5]), 32'(4));
    do_sweep();

    // 1024 pixels i mod 256 with idle gaps.
    do_clear(1'b0);
    bus.accum_en = 1'b1;
    for (int i = 0; i < 1024; i++) send_pixel(8'(i), 1'b1);
    end_accum();
    do_sweep();

    // Saturation: 20 hits on bin 3.
    do_clear(1'b0);
    bus.accum_en = 1'b1;
    for (int i = 0; i < 20; i++) send_pixel(8'd3, 1'b0);
    end_accum();
    do_sweep();

    // Clear beats sweep; a sweep_req during clear is dropped.
    do_clear(1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("no_sweep_after_clear", 32'({bus.sweep_valid, bus.busy}), 32'(0));
    end
    step();
    do_sweep();

    // Reset in sweep cycle 100.
    for (int b = 0; b < 256; b++) exp_q.push_back('{bin: 8'(b), cnt: CW'(hist[b]), last: (b == 255)});
    bus.sweep_req = 1'b1;
    @(posedge clk);
    #1 bus.sweep_req = 1'b0;
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_state", 32'({bus.sweep_valid, bus.busy, bus.ram_we}), 32'(0));
    step();
    reset = 1'b0;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", 32'({bus.sweep_valid, bus.busy, bus.ram_we}), 32'(0));
    end
    step();
    do_clear(1'b0);
    do_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hist_ram_scheduler.md
Name: hist_ram_scheduler

Overview:
- Owns the 256-bin histogram RAM and shares it between three requesters: the clear engine, pass-1 pixel accumulation, and the CDF sweep reader.
- Sits between the top-level controller and the simple dual-port histogram BRAM.
- Sequences read-modify-write increments at one pixel per cycle, with one-deep hazard forwarding.
- Emits a sequential bin-count stream for the CDF/LUT stage.

Parameters:
- CW, 21, bin count width; counts saturate at 2^CW-1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  pulse; request to zero all 256 bins
- accum_en  in  1  level; held high by the controller for the whole of pass 1
- pix_valid  in  1  pixel present on pix_data
- pix_data  in  8  pixel value (bin index)
- pix_ready  out  1  scheduler accepts a pixel this cycle
- sweep_req  in  1  pulse; request to read out bins 0..255
- sweep_valid  out  1  sweep_bin and sweep_count are valid
- sweep_bin  out  8  bin index of the current sweep word
- sweep_count  out  CW  count of that bin
- sweep_last  out  1  high with bin 255
- clear_done  out  1  one-cycle pulse after the final zero write
- busy  out  1  high in any state other than IDLE, or while the pipeline is non-empty
- overflow  out  1  sticky; a bin saturated. Cleared by reset or by the start of a clear.
- ram_rd_addr  out  8  BRAM read address
- ram_rd_data  in  CW  BRAM read data, valid 1 cycle after the address
- ram_we  out  1  BRAM write enable
- ram_wr_addr  out  8  BRAM write address
- ram_wr_data  out  CW  BRAM write data

Behaviour:
- The BRAM is read-first: a read and a write to the same address in the same cycle return the old data.
- Reset values: state IDLE; all outputs 0 (pix_ready, sweep_valid, sweep_last, clear_done, busy, overflow, ram_we, addresses, data). All pipeline valids are cleared.
- Reset mid-operation aborts the operation immediately; no further writes are issued. RAM contents are then undefined, and the controller must clear before the next pass 1.
- States: IDLE, CLEAR, ACCUM, SWEEP.
- IDLE arbitration, evaluated each cycle with fixed priority clear_req > sweep_req > accum_en:
  - Only the highest-priority request is taken.
  - Requests that arrive while not in IDLE are ignored, not queued.
- CLEAR:
  - Counter runs 0..255; ram_we=1, ram_wr_addr=counter, ram_wr_data=0; one write per cycle.
  - overflow clears on the first CLEAR cycle.
  - After the addr-255 write, clear_done pulses for one cycle in the next cycle, which is also the first cycle back in IDLE.
  - Total duration is 256 cycles in CLEAR.
- ACCUM:
  - pix_ready = accum_en. A pixel is accepted when pix_valid and pix_ready are both high.
  - Accept cycle t: ram_rd_addr=pix_data; stage-1 registers capture the address and valid.
  - Cycle t+1:
    - base = forward-register data if the forward register is valid and its address equals the stage-1 address; otherwise base = ram_rd_data.
    - Issue ram_we=1, ram_wr_addr=stage-1 address, ram_wr_data=base+1.
    - If base equals 2^CW-1, write base unchanged and set overflow.
    - Load the forward register with this write's address and data.
  - This gives one accepted pixel per cycle with no stalls. Back-to-back identical pixels count correctly.
  - When accum_en falls, pix_ready drops in the same cycle. The FSM returns to IDLE once stage 1 is empty, i.e. one cycle after the last write.
  - The forward register is invalidated on leaving ACCUM.
- SWEEP:
  - rd counter runs 0..255, one read per cycle; ram_we=0.
  - Each word appears one cycle after its read: sweep_valid=1, sweep_bin=address, sweep_count=ram_rd_data.
  - sweep_last accompanies bin 255.
  - There is no backpressure; the consumer must accept every cycle.
  - Return to IDLE the cycle after the bin-255 word.
- busy:
  - Low only when in IDLE with every pipeline stage empty.
  - The top controller uses busy to sequence clear -> accumulate -> sweep.
- Width rules:
  - The increment is CW-bit with saturation; no wrap is permitted.
  - Counters are 8-bit; the terminal value 255 is detected explicitly. Counters never wrap into a second pass.

Test Plan:
- Reset then clear_req -> ram_we high for exactly 256 cycles, addresses 0..255, data 0; clear_done pulses once at cycle 257; busy falls with it.
- Clear, then accumulate pixels 5,5,5,7,5 on consecutive cycles, then sweep -> bin 5 = 4, bin 7 = 1, all others 0. Sweep shows 256 valid words, bins in order, sweep_last only on bin 255.
- Clear, then 1024 pixels of value i mod 256 with pix_valid toggled randomly -> every bin = 4, and the sum of sweep_count = 1024.
- CW=4, clear, 20 pixels of value 3 -> bin 3 = 15, overflow=1. A subsequent clear_req drops overflow to 0.
- clear_req and sweep_req in the same IDLE cycle -> CLEAR runs. A sweep_req arriving during CLEAR is ignored: no sweep_valid until a new sweep_req arrives in IDLE.
- Assert reset at cycle 100 of a SWEEP -> the next cycle shows sweep_valid=0 and busy=0. No further RAM reads or writes occur, and the FSM is in IDLE.
